arb_mux_rr: RTL
===============

// Module: arb_mux_rr
// PURPOSE
//  Parametrised N-way, WIDTH-bit stream multiplexer with round-robin arbitration and one
//  registered output stage. Each input channel has a valid/ready handshake. Successor to the
//  fixed 8-way/16-bit combinational mux. Merges several producers (e.g. ALU and memory
//  read-back) onto one consumer bus.
// PARAMETERS
//  WIDTH  16  data bits per channel
//  N      8   number of input channels, 2..16
//  SELW   $clog2(N)  index width (derived, do not override)
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  reset      in   1        synchronous, active-high
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        channel i has a beat
//  in_ready   out  N        channel i beat accepted this cycle (one-hot or zero)
//  out_data   out  WIDTH    registered winning beat
//  out_valid  out  1        out_data holds an unconsumed beat
//  out_ready  in   1        consumer accepts out_data
//  out_sel    out  SELW     index of channel that produced out_data
// BEHAVIOUR
//  - Reset (sync, high): out_valid=0, out_data=0, out_sel=0, rr pointer=0 (channel 0 first).
//  - load_en = !out_valid || out_ready. Output register empty or drained this cycle.
//  - Winner: first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - in_ready[winner] = load_en && |in_valid. All other in_ready bits are 0.
//    in_ready is combinational from in_valid, out_valid, out_ready and ptr.
//  - On clk with load_en && |in_valid: out_data<=winner data, out_sel<=winner, out_valid<=1,
//    ptr<=(winner+1) mod N. Wrap: winner N-1 -> ptr 0.
//  - On clk with load_en && !|in_valid: out_valid<=0. out_data and out_sel hold their values.
//  - On clk with !load_en (stall): out_* and ptr hold. in_ready=0. Inputs must hold.
//  - Latency: 1 cycle input->output. Throughput: 1 beat/cycle while out_ready=1.
//  - Simultaneous drain + load: back-to-back, no bubble.
//  - Reset mid-transfer: registered beat is dropped and ptr returns to 0. in_ready=0 while reset=1.
//  - A channel that stays valid is granted within N beats (fairness bound).
// CONFIGURATION
//  - ARB_MUX_LOCK_EN defined: adds port in_last (in, N). After a grant to channel i, the
//    arbiter stays on i for every later load until a beat with in_last[i]=1 is accepted.
//    The rr pointer then advances to i+1. While locked and in_valid[i]=0, nothing is loaded,
//    even if other channels are valid. Reset clears the lock.
//  - ARB_MUX_LOCK_EN not defined: no in_last port. Re-arbitration on every beat as above.
// STRUCTURE
//  - Package arb_mux_pkg: function clog2_safe(N), min 1. Localparam SELW rule.
//    Typedef sel_t [SELW-1:0].
//  - Sub-module rr_arbiter #(N): combinational. Inputs req[N] and ptr. Outputs gnt one-hot,
//    gnt_idx and any_gnt. Implemented with a double-width rotate-and-priority scheme.
//  - Top: rr_arbiter, data select, output register, ptr register (+ lock flag under macro).
// TESTING
//  1. reset=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0.
//     First cycle after release grants ch0.
//  2. N=8, all valid, out_ready=1, in_data[i]=16'hA000+i -> out_sel 0,1,...,7,0.
//     out_data tracks each grant one cycle later. No bubbles.
//  3. Only ch5 valid, data 16'h1234 -> in_ready=8'b0010_0000. Next cycle out_data=16'h1234,
//     out_sel=5. ptr=6, so ch6 wins over ch4 when both are raised next.
//  4. Stall: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_* stable.
//     out_ready=1 -> drain and next load on the same edge.
//  5. Reset asserted while out_valid=1, out_sel=3 -> next cycle out_valid=0, ptr=0.
//  6. LOCK_EN: ch2 sends 3 beats with last on beat 3, ch1 valid throughout -> out_sel 2,2,2,
//     then 1. A gap in ch2 mid-packet gives out_valid=0 for that cycle, with no ch1 grant.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared helpers and types for the round-robin stream multiplexer.
// Optional packet locking is enabled by defining ARB_MUX_LOCK_EN.
package arb_mux_pkg;

  // Index width for n channels, never below one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default channel count and its index width.
  localparam int N_DEF    = 8;
  localparam int SELW_DEF = clog2_safe(N_DEF);

  typedef logic [SELW_DEF-1:0] sel_t;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter. The request vector is doubled, rotated
// so that the pointer's channel sits at bit 0, and priority-encoded. The
// offset is then added back to the pointer modulo N.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int N    = 8,
  localparam int SELW = clog2_safe(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic            found;
  logic [SELW:0]   sum;

  // Rotate, find the first requester at or after ptr, and map it back.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    off     = '0;
    found   = 1'b0;
    rot     = N'({req, req} >> ptr);
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = SELW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
    gnt_idx = sum[SELW-1:0];
    any_gnt = |req;
    gnt     = any_gnt ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-way WIDTH-bit valid/ready stream mux with round-robin arbitration and a
// single registered output stage. Define ARB_MUX_LOCK_EN to add in_last and
// hold the grant on one channel until its last beat is accepted.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = clog2_safe(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
`ifdef ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
`endif

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] gnt_idx;
  logic            any_gnt;
  logic            load_en;
  logic            accept;

  // Requests presented to the arbiter; mid-packet only the locked channel counts.
  always_comb begin
    req = in_valid;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q) req = in_valid & (N'(1) << out_sel_q);
`endif
  end

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Output register is free when empty or being drained this cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign accept   = load_en && any_gnt && !reset;
  assign in_ready = accept ? gnt : '0;

  // Next-state for the output stage, round-robin pointer and lock flag.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef ARB_MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    if (accept) begin
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      ptr_d       = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
`ifdef ARB_MUX_LOCK_EN
      lock_d      = !in_last[gnt_idx];
`endif
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule
